// File: rtl/uart_tx_framer_pkg.sv
// rtl/uart_tx_framer_pkg.sv - shared UART constants, TX state encoding and parity helper
//
// Purpose: constants and types shared by the UART transmit path and its baud generator.
// Ports: none (package).
package uart_tx_framer_pkg;

  localparam int UART_DATA_LENGTH = 8;

  localparam int UART_PARITY_NONE = 0;
  localparam int UART_PARITY_EVEN = 1;
  localparam int UART_PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_e;

  // data_xor is the XOR-reduction of the data bits; odd parity inverts it so
  // that data plus parity carries an odd number of ones.
  function automatic logic uart_parity_bit(input logic data_xor, input int mode);
    return (mode == UART_PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with synchronous restart
//
// Purpose: counts CLKS_PER_BIT clock cycles per bit and flags the last cycle.
// Ports:
//   clk_i      system clock
//   rstn_i     asynchronous active-low reset
//   restart_i  synchronous restart, holds the counter at zero
//   bit_end_o  high on the final cycle of each bit period
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic restart_i,
  output logic bit_end_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (restart_i || (cnt_q == CNT_MAX)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bit_end_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmitter: start, data LSB first, optional parity, stop bits
//
// Purpose: serialises one parallel word per handshake onto an idle-high TX line.
// Ports:
//   clk_i      system clock
//   rstn_i     asynchronous active-low reset
//   tx_i       word to send
//   tx_i_v     tx_i valid
//   tx_i_rdy   word can be accepted (IDLE only)
//   tx_o       registered serial line, idle high
//   tx_o_v     frame in progress
//   tx_done_o  one-cycle pulse on the last stop-bit cycle
module uart_tx_framer
  import uart_tx_framer_pkg::*;
#(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int DATA_WIDTH = UART_DATA_LENGTH,
  parameter int PARITY     = UART_PARITY_NONE,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [DATA_WIDTH-1:0] tx_i,
  input  logic                  tx_i_v,
  output logic                  tx_i_rdy,
  output logic                  tx_o,
  output logic                  tx_o_v,
  output logic                  tx_done_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int IDX_W        = $clog2(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_tx_state_e        state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  stop_idx_q, stop_idx_d;
  logic                  tx_q, tx_d;
  logic                  restart;
  logic                  bit_end;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .restart_i(restart),
    .bit_end_o(bit_end)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
    end
  end

  // tx_d is the line value for the next cycle, so each transition loads the
  // first value of the bit being entered.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    restart    = 1'b0;
    tx_done_o  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Holding the baud counter in restart aligns bit periods to the accept edge.
        restart = 1'b1;
        tx_d    = 1'b1;
        if (tx_i_v) begin
          shift_d    = tx_i;
          parity_d   = uart_parity_bit(^tx_i, PARITY);
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          tx_d       = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_IDX) begin
            if (PARITY != UART_PARITY_NONE) begin
              tx_d    = parity_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + IDX_W'(1);
            tx_d      = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            tx_done_o = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign tx_i_rdy = (state_q == ST_IDLE);
  assign tx_o_v   = (state_q != ST_IDLE);
  assign tx_o     = tx_q;

endmodule
